// File: rtl/nonbin_class_updater_if.sv
// -----------------------------------------------------------------------------
// nonbin_class_updater_if
//   Handshake and class-register bus between the nonbinary class updater and
//   its surroundings (query source plus the nonbinary class register).
//
//   master : environment side (drives start/op, query chunks, register read data)
//   slave  : updater side (drives query handshake, register select/write port,
//            status outputs)
//
//   start                       request to begin an update (one cycle)
//   op                          00 add, 01 subtract, 10 clear, 11 rewrite
//   qry_valid / qry_ready       query chunk handshake
//   qry_chunk                   binary query bits of the current chunk
//   class_ctr                   read-mux select into the class register
//   nonbin_class_reg_out        chunk read back from the class register
//   adjusting_nonbin_class_hvs  write strobe into the class register
//   nonbin_ctr                  write chunk index
//   nonbin_class_reg_in         write data
//   busy / done / sat_count     status of the update sequence
// -----------------------------------------------------------------------------
interface nonbin_class_updater_if #(
   parameter int DIMS_PER_CC      = 500,
   parameter int BITWIDTH_PER_DIM = 9
);
   localparam int CHUNK_W = DIMS_PER_CC * BITWIDTH_PER_DIM;

   logic                   start;
   logic [1:0]             op;
   logic                   qry_valid;
   logic [DIMS_PER_CC-1:0] qry_chunk;
   logic                   qry_ready;
   logic [3:0]             class_ctr;
   logic [CHUNK_W-1:0]     nonbin_class_reg_out;
   logic                   adjusting_nonbin_class_hvs;
   logic [3:0]             nonbin_ctr;
   logic [CHUNK_W-1:0]     nonbin_class_reg_in;
   logic                   busy;
   logic                   done;
   logic [12:0]            sat_count;

   modport master (
      output start, op, qry_valid, qry_chunk, nonbin_class_reg_out,
      input  qry_ready, class_ctr, adjusting_nonbin_class_hvs, nonbin_ctr,
             nonbin_class_reg_in, busy, done, sat_count
   );

   modport slave (
      input  start, op, qry_valid, qry_chunk, nonbin_class_reg_out,
      output qry_ready, class_ctr, adjusting_nonbin_class_hvs, nonbin_ctr,
             nonbin_class_reg_in, busy, done, sat_count
   );
endinterface

// File: rtl/nonbin_class_updater.sv
// -----------------------------------------------------------------------------
// nonbin_class_updater
//   Walks a stored nonbinary class HV chunk by chunk. Each chunk is read
//   through the class register's read mux (FETCH), combined with the binary
//   query chunk (saturating add / saturating subtract / clear / rewrite) and
//   written back on the following cycle (WRITE). Dims that hit a rail while
//   their query bit is set are counted and reported in sat_count when the
//   sequence finishes.
//
//   clk    clock
//   nrst   asynchronous active-low reset
//   bus    nonbin_class_updater_if.slave (handshake, register bus, status)
// -----------------------------------------------------------------------------
module nonbin_class_updater #(
   parameter int DIMS_PER_CC      = 500,
   parameter int BITWIDTH_PER_DIM = 9,
   parameter int SEQ_CYCLE_COUNT  = 10
) (
   input logic                  clk,
   input logic                  nrst,
   nonbin_class_updater_if.slave bus
);
   localparam int         BW      = BITWIDTH_PER_DIM;
   localparam int         CHUNK_W = DIMS_PER_CC * BW;
   localparam int         CNT_W   = $clog2(DIMS_PER_CC + 1);
   localparam logic [3:0] LAST_K  = 4'(SEQ_CYCLE_COUNT - 1);

   // Two's-complement rails: +2^(BW-1)-1 and -2^(BW-1).
   localparam logic [BW-1:0] POS_RAIL = {1'b0, {(BW-1){1'b1}}};
   localparam logic [BW-1:0] NEG_RAIL = {1'b1, {(BW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                             OP_CLEAR = 2'b10, OP_KEEP = 2'b11} op_t;

   state_t             state;
   op_t                op_q;
   logic [3:0]         k;
   logic [12:0]        acc;
   logic [CHUNK_W-1:0] wr_data;
   logic               adjusting;
   logic [3:0]         wr_idx;
   logic               busy_q;
   logic               done_q;
   logic [12:0]        sat_q;

   // Per-chunk datapath
   logic [CHUNK_W-1:0] next_chunk;
   logic [CNT_W-1:0]   chunk_sat;
   logic [BW-1:0]      cur;
   logic [BW-1:0]      nxt;
   logic               qbit;

   // NOTE: every variable written here gets a default first so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      next_chunk = '0;
      chunk_sat  = '0;
      cur        = '0;
      nxt        = '0;
      qbit       = 1'b0;
      for (int d = 0; d < DIMS_PER_CC; d++) begin
         cur  = bus.nonbin_class_reg_out[d*BW +: BW];
         qbit = bus.qry_chunk[d];
         case (op_q)
            OP_ADD: begin
               // A dim at the rail with its bit set stays put and counts.
               if (qbit && cur == POS_RAIL) begin
                  nxt       = cur;
                  chunk_sat = chunk_sat + CNT_W'(1);
               end else begin
                  nxt = cur + {{(BW-1){1'b0}}, qbit};
               end
            end
            OP_SUB: begin
               if (qbit && cur == NEG_RAIL) begin
                  nxt       = cur;
                  chunk_sat = chunk_sat + CNT_W'(1);
               end else begin
                  nxt = cur - {{(BW-1){1'b0}}, qbit};
               end
            end
            OP_CLEAR: nxt = '0;
            default:  nxt = cur;
         endcase
         next_chunk[d*BW +: BW] = nxt;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         op_q      <= OP_ADD;
         k         <= '0;
         acc       <= '0;
         // NOTE: the write-data register drives an output that must read 0
         // from reset, so unlike a storage array it is reset here.
         wr_data   <= '0;
         adjusting <= 1'b0;
         wr_idx    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sat_q     <= '0;
      end else begin
         // Strobe-type outputs are high only in the state entered this edge.
         adjusting <= 1'b0;
         wr_idx    <= '0;
         done_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q   <= op_t'(bus.op);
                  acc    <= '0;
                  k      <= '0;
                  busy_q <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               // Query handshake paces every chunk, clear included.
               if (bus.qry_valid) begin
                  wr_data   <= next_chunk;
                  acc       <= acc + 13'(chunk_sat);
                  adjusting <= 1'b1;
                  wr_idx    <= k;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (k == LAST_K) begin
                  k      <= '0;
                  done_q <= 1'b1;
                  sat_q  <= acc;
                  state  <= S_DONE;
               end else begin
                  k     <= k + 4'd1;
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // k returns to 0 outside an operation, so the read select idles at 0.
   assign bus.class_ctr                  = k;
   assign bus.qry_ready                  = (state == S_FETCH) && bus.qry_valid;
   assign bus.adjusting_nonbin_class_hvs = adjusting;
   assign bus.nonbin_ctr                 = wr_idx;
   assign bus.nonbin_class_reg_in        = wr_data;
   assign bus.busy                       = busy_q;
   assign bus.done                       = done_q;
   assign bus.sat_count                  = sat_q;
endmodule

// File: doc/nonbin_class_updater.md
Name: nonbin_class_updater

Overview:
Sequencer and arithmetic stage directly upstream of the nonbinary class register. On each training update it walks the stored class HV one chunk at a time (SEQ_CYCLE_COUNT chunks of DIMS_PER_CC dims). For each chunk it reads the current values through the register's read mux, adds, subtracts or clears against a binary query chunk with saturation, and writes the result back through the register's write port. It also counts the dims that saturated during the operation.

Parameters:
DIMS_PER_CC, 500, dims per chunk.
BITWIDTH_PER_DIM, 9, signed two's-complement width per dim.
SEQ_CYCLE_COUNT, 10, number of chunks per class HV (must be ≤16).

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin an update
op  in  2  00 add, 01 subtract, 10 clear, 11 rewrite unchanged; sampled with start
qry_valid  in  1  query chunk for current index is present
qry_chunk  in  DIMS_PER_CC  binary query bits for current chunk
qry_ready  out  1  query chunk consumed this cycle
class_ctr  out  4  read-mux select to class register
nonbin_class_reg_out  in  DIMS_PER_CC*BITWIDTH_PER_DIM  current chunk from class register (combinational on class_ctr)
adjusting_nonbin_class_hvs  out  1  write strobe to class register
nonbin_ctr  out  4  write chunk index to class register
nonbin_class_reg_in  out  DIMS_PER_CC*BITWIDTH_PER_DIM  write data to class register
busy  out  1  operation in progress
done  out  1  one-cycle pulse after last chunk written
sat_count  out  13  saturated-dim count of the last completed operation

Behaviour:
- Reset (async, nrst low): state IDLE; chunk index k=0; op_q=00. All outputs are 0, including sat_count, and the internal sat accumulator is 0. Reset mid-operation abandons the update; chunks already written stay written.
- IDLE: class_ctr=0, nonbin_ctr=0, adjusting=0, qry_ready=0.
  - start=1 → latch op into op_q, clear the sat accumulator, set k=0, go to FETCH. busy is 1 from the next cycle.
- FETCH: class_ctr=k.
  - If qry_valid=1: qry_ready=1 this cycle. Register for every dim d: wr_data[d]=f(nonbin_class_reg_out[d], qry_chunk[d]). Add that chunk's saturated-dim count to the accumulator. Go to WRITE.
  - If qry_valid=0: hold in FETCH with qry_ready=0. No timeout.
  - op_q=10 (clear): qry_valid is still required as the pacing handshake.
- f per op_q, with v = signed stored value and b = query bit:
  - add: v+b, saturate at +255.
  - subtract: v−b, saturate at −256.
  - clear: 0.
  - rewrite: v.
  - A dim counts as saturated only when b=1 and v is already at the rail for that direction. Dims with b=0 never count.
- WRITE: adjusting_nonbin_class_hvs=1, nonbin_ctr=k, nonbin_class_reg_in=wr_data, class_ctr=k.
  - If k=SEQ_CYCLE_COUNT−1: go to DONE.
  - Else: k←k+1, go to FETCH.
- DONE: done=1 for one cycle; sat_count ← accumulator (total over all chunks); go to IDLE.
- Outside WRITE, adjusting=0; nonbin_class_reg_in holds its last value.
- busy=1 in FETCH, WRITE and DONE.
- start while busy is ignored; op is not re-sampled.
- Latency: minimum 2*SEQ_CYCLE_COUNT+1 cycles from the start cycle to the done pulse (21 with defaults). Each qry_valid stall cycle adds 1.
- Read-before-write is guaranteed: chunk k is read in FETCH and written in the following WRITE. No chunk is written twice per operation.
- sat_count width 13 covers the maximum of 5000 dims. It is stable between done pulses.

Test Plan:
- Reset, class reg all 0, start op=00, all qry_chunk bits 1, qry_valid held high → done exactly 21 cycles after start. 10 write strobes with nonbin_ctr 0..9 in order. Every dim = 1. sat_count=0.
- Class reg preloaded with every dim = 255, op=00, chunk 3 has 7 bits set, other chunks all 0 → values unchanged. sat_count=7.
- Every dim = −256, op=01, all bits 1 → all stay −256; sat_count=5000. Repeat with every dim = 5 → all become 4, sat_count=0.
- op=10 with arbitrary preload, qry_valid dropped for 3 cycles during chunk 4 → all dims 0. Done at 24 cycles after start. qry_ready pulses exactly 10 times.
- start pulsed again 5 cycles into an operation with op=01 → ignored: 10 strobes only, op=00 result, single done.
- nrst asserted during WRITE of chunk 6 → outputs 0 immediately; chunks 0..5 updated, 6..9 untouched. A fresh start then completes normally.
